// File: rtl/shift_register_sequencer.sv
// shift_register_sequencer
//   Command-driven controller for a 4-bit bidirectional shift register
//   (S1/S0 mode, D, DSL, DSR, CP). A host offers one command at a time
//   (LOAD, ROTR N, ROTL N, SERIN N) over a valid/ready handshake. The
//   controller drives the register's mode and serial pins for exactly the
//   required number of CP edges, then pulses DONE for one cycle.
//
// Ports
//   CP         clock, rising edge, shared with the shift register
//   CR         asynchronous active-low reset
//   CMD_VALID  command offered        CMD_READY  command can be accepted
//   CMD_OP     00 LOAD, 01 ROTR, 10 ROTL, 11 SERIN
//   CMD_N      shift count (ignored for LOAD)
//   CMD_DATA   parallel word for LOAD
//   ABORT      synchronous abort of the running command
//   SIN        serial data for SERIN  SIN_TAKE   SIN consumed at this edge
//   Q          shift register outputs (rotate feedback)
//   S1, S0     register mode: 11 load, 10 toward Q[0], 01 toward Q[MSB], 00 hold
//   D          register parallel input
//   DSL, DSR   register serial inputs
//   BUSY       command in progress    DONE       command completed normally
module shift_register_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             CP,
  input  logic             CR,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [CNT_W-1:0] CMD_N,
  input  logic [WIDTH-1:0] CMD_DATA,
  input  logic             ABORT,
  input  logic             SIN,
  output logic             SIN_TAKE,
  input  logic [WIDTH-1:0] Q,
  output logic             S1,
  output logic             S0,
  output logic [WIDTH-1:0] D,
  output logic             DSL,
  output logic             DSR,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    FIN  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_ROTR  = 2'b01,
    OP_ROTL  = 2'b10,
    OP_SERIN = 2'b11
  } op_t;

  state_t           state;
  op_t              op;
  logic [WIDTH-1:0] data;
  logic [CNT_W-1:0] count;

  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      state <= IDLE;
      op    <= OP_LOAD;
      data  <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (CMD_VALID && !ABORT) begin
            op   <= op_t'(CMD_OP);
            data <= CMD_DATA;
            if (op_t'(CMD_OP) == OP_LOAD) begin
              count <= CNT_W'(1);
              state <= EXEC;
            end else if (CMD_N == '0) begin
              // Zero-length shift: no register edge, report completion directly.
              count <= '0;
              state <= FIN;
            end else begin
              count <= CMD_N;
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          if (ABORT) begin
            state <= IDLE;
          end else begin
            count <= count - CNT_W'(1);
            if (count == CNT_W'(1)) state <= FIN;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Register-facing pins are active only while executing and not aborted,
  // so an abort cycle leaves the register holding.
  always_comb begin
    S1       = 1'b0;
    S0       = 1'b0;
    DSL      = 1'b0;
    DSR      = 1'b0;
    SIN_TAKE = 1'b0;
    if (state == EXEC && !ABORT) begin
      case (op)
        OP_LOAD: begin
          S1 = 1'b1;
          S0 = 1'b1;
        end
        OP_ROTR: begin
          S0  = 1'b1;
          DSR = Q[WIDTH-1];
        end
        OP_ROTL: begin
          S1  = 1'b1;
          DSL = Q[0];
        end
        OP_SERIN: begin
          S0       = 1'b1;
          DSR      = SIN;
          SIN_TAKE = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign D         = data;
  assign BUSY      = (state != IDLE);
  assign DONE      = (state == FIN);
  assign CMD_READY = (state == IDLE) && !ABORT;

endmodule

// File: tb/tb_shift_register_sequencer.sv
// tb_shift_register_sequencer
//   Drives the sequencer against a behavioural 4-bit bidirectional shift
//   register and checks register contents, DONE latency, SIN_TAKE and load
//   pulse counts, plus reset, abort and back-to-back handshake sequences.
module tb_shift_register_sequencer;

  logic       CP = 1'b0;
  logic       CR;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [1:0] CMD_OP;
  logic [2:0] CMD_N;
  logic [3:0] CMD_DATA;
  logic       ABORT;
  logic       SIN;
  logic       SIN_TAKE;
  logic [3:0] Q = 4'b0000;
  logic       S1, S0;
  logic [3:0] D;
  logic       DSL, DSR;
  logic       BUSY;
  logic       DONE;

  int errors = 0;
  int checks = 0;

  shift_register_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .CP(CP), .CR(CR), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_N(CMD_N), .CMD_DATA(CMD_DATA), .ABORT(ABORT),
    .SIN(SIN), .SIN_TAKE(SIN_TAKE), .Q(Q), .S1(S1), .S0(S0), .D(D),
    .DSL(DSL), .DSR(DSR), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CP = ~CP;

  // Behavioural shift register sharing CP.
  always @(posedge CP) begin
    case ({S1, S0})
      2'b11:   Q <= D;
      2'b01:   Q <= {Q[2:0], DSR};
      2'b10:   Q <= {DSL, Q[3:1]};
      default: Q <= Q;
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [2:0] n;
    logic [3:0] data;
    logic [7:0] pat;     // bit i = i-th serial bit shifted in
    logic [3:0] exp_q;
    int         exp_lat; // cycles from accept cycle to DONE cycle
    int         exp_takes;
    int         exp_loads;
  } vec_t;

  function automatic vec_t mk(logic [1:0] op, logic [2:0] n, logic [3:0] data,
                              logic [7:0] pat, logic [3:0] q, int lat, int tk, int ld);
    vec_t v;
    v.op = op; v.n = n; v.data = data; v.pat = pat;
    v.exp_q = q; v.exp_lat = lat; v.exp_takes = tk; v.exp_loads = ld;
    return v;
  endfunction

  task automatic run_cmd(input vec_t v, input int id);
    int lat   = -1;
    int takes = 0;
    int loads = 0;
    @(negedge CP);
    chk($sformatf("v%0d ready", id), CMD_READY, 1);
    CMD_VALID = 1'b1;
    CMD_OP    = v.op;
    CMD_N     = v.n;
    CMD_DATA  = v.data;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge CP);
      CMD_VALID = 1'b0;
      if (SIN_TAKE) begin
        SIN = v.pat[takes];
        takes++;
      end
      if (S1 && S0) loads++;
      if (DONE) lat = k;
    end
    chk($sformatf("v%0d latency", id), lat, v.exp_lat);
    chk($sformatf("v%0d q", id), Q, v.exp_q);
    chk($sformatf("v%0d sin_take", id), takes, v.exp_takes);
    chk($sformatf("v%0d loads", id), loads, v.exp_loads);
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = mk(2'b00, 3'd0, 4'b1011, 8'h00, 4'b1011, 2, 0, 1);
    vecs[1]  = mk(2'b00, 3'd3, 4'b1000, 8'h00, 4'b1000, 2, 0, 1);
    vecs[2]  = mk(2'b01, 3'd1, 4'b0000, 8'h00, 4'b0001, 2, 0, 0);
    vecs[3]  = mk(2'b10, 3'd5, 4'b0000, 8'h00, 4'b1000, 6, 0, 0);
    vecs[4]  = mk(2'b00, 3'd0, 4'b0110, 8'h00, 4'b0110, 2, 0, 1);
    vecs[5]  = mk(2'b01, 3'd4, 4'b0000, 8'h00, 4'b0110, 5, 0, 0);
    vecs[6]  = mk(2'b10, 3'd1, 4'b0000, 8'h00, 4'b0011, 2, 0, 0);
    vecs[7]  = mk(2'b11, 3'd4, 4'b0000, 8'b00001011, 4'b1101, 5, 4, 0);
    vecs[8]  = mk(2'b11, 3'd0, 4'b0000, 8'h00, 4'b1101, 1, 0, 0);
    vecs[9]  = mk(2'b01, 3'd0, 4'b0000, 8'h00, 4'b1101, 1, 0, 0);
    vecs[10] = mk(2'b11, 3'd6, 4'b0000, 8'b00100110, 4'b1001, 7, 6, 0);
    vecs[11] = mk(2'b10, 3'd7, 4'b0000, 8'h00, 4'b0011, 8, 0, 0);

    CR = 1'b0; CMD_VALID = 1'b0; CMD_OP = 2'b00; CMD_N = '0;
    CMD_DATA = '0; ABORT = 1'b0; SIN = 1'b0;
    @(negedge CP);
    chk("reset s", {S1, S0}, 2'b00);
    chk("reset busy", BUSY, 0);
    chk("reset done", DONE, 0);
    chk("reset d", D, 4'b0000);
    chk("reset dsl_dsr", {DSL, DSR}, 2'b00);
    chk("reset sin_take", SIN_TAKE, 0);
    @(negedge CP);
    CR = 1'b1;
    chk("idle ready", CMD_READY, 1);

    foreach (vecs[i]) run_cmd(vecs[i], i);

    // Asynchronous reset while a rotate is executing.
    @(negedge CP);
    CMD_VALID = 1'b1; CMD_OP = 2'b01; CMD_N = 3'd7;
    @(negedge CP);
    CMD_VALID = 1'b0;
    chk("rst pre busy", BUSY, 1);
    @(negedge CP);
    #2 CR = 1'b0;
    #1;
    chk("rst mid s", {S1, S0}, 2'b00);
    chk("rst mid busy", BUSY, 0);
    chk("rst mid done", DONE, 0);
    chk("rst mid ready", CMD_READY, 1);
    @(negedge CP);
    CR = 1'b1;

    // Abort on the second EXEC cycle of ROTR 3 from 0001.
    run_cmd(mk(2'b00, 3'd0, 4'b0001, 8'h00, 4'b0001, 2, 0, 1), 100);
    @(negedge CP);
    CMD_VALID = 1'b1; CMD_OP = 2'b01; CMD_N = 3'd3;
    @(negedge CP);
    CMD_VALID = 1'b0;
    chk("abort exec1 s", {S1, S0}, 2'b01);
    @(negedge CP);
    ABORT = 1'b1;
    #1;
    chk("abort s", {S1, S0}, 2'b00);
    chk("abort ready", CMD_READY, 0);
    @(negedge CP);
    ABORT = 1'b0;
    #1;
    chk("abort busy", BUSY, 0);
    chk("abort done", DONE, 0);
    chk("abort ready after", CMD_READY, 1);
    chk("abort q", Q, 4'b0010);
    @(negedge CP);
    chk("abort no done", DONE, 0);
    chk("abort q held", Q, 4'b0010);

    // Back-to-back: VALID held across LOAD 0001 then ROTL 2.
    CMD_VALID = 1'b1; CMD_OP = 2'b00; CMD_DATA = 4'b0001; CMD_N = 3'd0;
    chk("b2b ready0", CMD_READY, 1);
    @(negedge CP);
    CMD_OP = 2'b10; CMD_N = 3'd2;
    chk("b2b exec busy", BUSY, 1);
    chk("b2b exec ready", CMD_READY, 0);
    @(negedge CP);
    chk("b2b fin done", DONE, 1);
    chk("b2b fin ready", CMD_READY, 0);
    chk("b2b load q", Q, 4'b0001);
    @(negedge CP);
    chk("b2b idle ready", CMD_READY, 1);
    chk("b2b idle busy", BUSY, 0);
    @(negedge CP);
    CMD_VALID = 1'b0;
    chk("b2b rotl s", {S1, S0}, 2'b10);
    chk("b2b rotl ready", CMD_READY, 0);
    @(negedge CP);
    chk("b2b rotl done early", DONE, 0);
    @(negedge CP);
    ABORT = 1'b1;
    chk("b2b rotl done", DONE, 1);
    chk("b2b rotl q", Q, 4'b0100);
    @(negedge CP);
    ABORT = 1'b0;
    chk("b2b done pulse", DONE, 0);
    chk("b2b final busy", BUSY, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
